alu_exec_unit: RTL and testbench

- Multi-cycle execute-stage ALU; consumes the 4-bit `Operation` code from the ALU controller, plus two operands.
- Produces the registered result and `Zero` flag, with valid/ready handshakes on both sides.
- Logic, add/sub, compare and equality ops complete in one cycle. Shifts use an area-saving serial shifter, one bit position per cycle, and `busy` stalls the pipeline meanwhile.

---
 rtl/alu_exec_unit_if.sv | 34 +++
 rtl/alu_exec_unit.sv | 167 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit_if
//  Description : Request/response bundle for the execute-stage ALU.
//                master drives the operation and consumes the result;
//                slave is the ALU itself.
//                Request : in_valid, in_ready, Operation, SrcA, SrcB
//                Response: out_valid, out_ready, ALUResult, Zero
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_exec_unit_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        Operation;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Multi-cycle execute-stage ALU. Logic, add/sub, compare and
//                equality ops finish in one cycle; shifts run on a serial
//                shifter moving one bit position per cycle.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous active-high reset
//                flush  - synchronous abort of in-flight op and held result
//                bus    - alu_exec_unit_if.slave (operation in, result out)
//                busy   - high while a serial shift is in progress
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    alu_exec_unit_if.slave      bus,
    output logic                busy
);

    localparam int SW = $clog2(DATA_W);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SLL = 4'b0011;
    localparam logic [3:0] c_OP_SRL = 4'b0100;
    localparam logic [3:0] c_OP_SRA = 4'b0101;
    localparam logic [3:0] c_OP_XOR = 4'b0110;
    localparam logic [3:0] c_OP_OR  = 4'b0111;
    localparam logic [3:0] c_OP_SLT = 4'b1000;
    localparam logic [3:0] c_OP_EQ  = 4'b1001;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic [SW-1:0]     cnt_q,       cnt_d;
    logic [DATA_W-1:0] work_q,      work_d;
    logic [3:0]        op_q,        op_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic              zero_q,      zero_d;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_shift;
    logic [SW-1:0]     w_shamt;
    logic [DATA_W-1:0] w_single;
    logic [DATA_W-1:0] w_step;

    // Output register may be refilled whenever it is empty or being drained
    // this cycle; reset and flush both block acceptance.
    assign w_in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready)
                        && !flush && !reset;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_shamt    = bus.SrcB[SW-1:0];
    assign w_is_shift = (bus.Operation == c_OP_SLL) || (bus.Operation == c_OP_SRL)
                        || (bus.Operation == c_OP_SRA);

    // Single-cycle result. Shift ops only land here with shamt == 0, where the
    // result is SrcA unchanged, so no barrel shifter is needed.
    always_comb begin
        w_single = bus.SrcA & bus.SrcB;
        case (bus.Operation)
            c_OP_SUB: w_single = bus.SrcA - bus.SrcB;
            c_OP_ADD: w_single = bus.SrcA + bus.SrcB;
            c_OP_SLL,
            c_OP_SRL,
            c_OP_SRA: w_single = bus.SrcA;
            c_OP_XOR: w_single = bus.SrcA ^ bus.SrcB;
            c_OP_OR:  w_single = bus.SrcA | bus.SrcB;
            c_OP_SLT: w_single = {{(DATA_W-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            c_OP_EQ:  w_single = {{(DATA_W-1){1'b0}}, (bus.SrcA == bus.SrcB)};
            default:  w_single = bus.SrcA & bus.SrcB;
        endcase
    end

    // One-position step of the serial shifter in the latched direction.
    always_comb begin
        case (op_q)
            c_OP_SLL: w_step = {work_q[DATA_W-2:0], 1'b0};
            c_OP_SRL: w_step = {1'b0, work_q[DATA_W-1:1]};
            default:  w_step = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;

        if (flush) begin
            // Held result is dropped but its value stays on ALUResult/Zero.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            work_d  = bus.SrcA;
                            cnt_d   = w_shamt;
                            op_d    = bus.Operation;
                            state_d = ST_SHIFT;
                        end else begin
                            result_d    = w_single;
                            zero_d      = (w_single == '0);
                            out_valid_d = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_d = w_step;
                    cnt_d  = cnt_q - SW'(1);
                    if (cnt_q == SW'(1)) begin
                        result_d    = w_step;
                        zero_d      = (w_step == '0);
                        out_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
    assign busy          = (state_q == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Self-checking bench for alu_exec_unit: directed vector
//                table, handshake corner sequences, and a randomized run
//                against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;

    logic clk;
    logic reset;
    logic flush;
    logic busy;

    alu_exec_unit_if #(.DATA_W(32)) bus ();

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          negs;   // falling edges from accept until out_valid seen
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    // Reference ALU from the op definitions, shifts done in one step.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd1:    return a - b;
            4'd2:    return a + b;
            4'd3:    return a << sh;
            4'd4:    return a >> sh;
            4'd5:    return 32'($signed(a) >>> sh);
            4'd6:    return a ^ b;
            4'd7:    return a | b;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a == b) ? 32'd1 : 32'd0;
            default: return a & b;
        endcase
    endfunction

    // Called at a falling edge; returns just after the accepting rising edge.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output bit ok);
        int w;
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        ok = 1'b0;
        for (w = 0; w < 50; w++) begin
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now("accept");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.Operation = 4'hx;
        bus.SrcA      = 'x;
        bus.SrcB      = 'x;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z,
                         output int lat, output int busy_cyc, output int rdy_low);
        bit ok;
        bus.out_ready = 1'b1;
        lat = 0; busy_cyc = 0; rdy_low = 0; res = 'x; z = 1'bx;
        start_op(op, a, b, ok);
        if (!ok) return;
        forever begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
            if (!bus.in_ready && !bus.out_valid) rdy_low++;
            if (bus.out_valid) break;
            if (lat > 100) begin
                fail_now("result");
                return;
            end
        end
        res = bus.ALUResult;
        z   = bus.Zero;
    endtask

    // Transaction-level model state for the random run.
    bit          m_pend, m_held, m_ready, m_acc;
    int          m_rem;
    logic [31:0] m_pres, m_res;

    initial begin
        logic [31:0] res;
        logic        z;
        int          lat, bc, rl, k;
        bit          ok, seen;

        vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
        vecs[1]  = '{4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1};
        vecs[2]  = '{4'b0101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 5};
        vecs[3]  = '{4'b0100, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 5};
        vecs[4]  = '{4'b0011, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1};
        vecs[5]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
        vecs[6]  = '{4'b1001, 32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 1'b0, 1};
        vecs[7]  = '{4'b1001, 32'h0000_1234, 32'h0000_1235, 32'h0000_0000, 1'b1, 1};
        vecs[8]  = '{4'b1111, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1};
        vecs[9]  = '{4'b0000, 32'hFFFF_00FF, 32'h0F0F_0F0F, 32'h0F0F_000F, 1'b0, 1};
        vecs[10] = '{4'b0111, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1};
        vecs[11] = '{4'b0110, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[12] = '{4'b0011, 32'h0000_0001, 32'hFFFF_FF1F, 32'h8000_0000, 1'b0, 32};
        vecs[13] = '{4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};

        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.Operation = 4'h0; bus.SrcA = '0; bus.SrcB = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        check("in_ready_during_reset", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result",    bus.ALUResult, 32'd0);
        check("rst_zero",      {31'd0, bus.Zero}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);

        // ---------------- directed vectors ----------------
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, bc, rl);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].z});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].negs);
            check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].negs - 1);
            check($sformatf("vec%0d_ready_low", i), rl, vecs[i].negs - 1);
            @(negedge clk);
        end

        // ---------------- backpressure then no-bubble reload ----------------
        bus.out_ready = 1'b0;
        start_op(4'b0111, 32'h00F0_0000, 32'h0000_000F, ok);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_result",    bus.ALUResult, 32'h00F0_000F);
            check("bp_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.Operation = 4'b0110;
        bus.SrcA      = 32'hFF00_FF00;
        bus.SrcB      = 32'h0F0F_0F0F;
        #1;
        check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_xor_valid",  {31'd0, bus.out_valid}, 32'd1);
        check("bp_xor_result", bus.ALUResult, 32'hF00F_F00F);
        @(negedge clk);
        check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        // ---------------- flush mid-shift ----------------
        start_op(4'b0100, 32'hDEAD_BEEF, 32'd20, ok);
        repeat (4) @(negedge clk);
        check("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.Operation = 4'b0010; bus.SrcA = 32'd1; bus.SrcB = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_busy",      {31'd0, busy}, 32'd0);
        check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_no_result", {31'd0, seen}, 32'd0);

        // ---------------- reset mid-shift ----------------
        start_op(4'b0100, 32'hDEAD_BEEF, 32'd20, ok);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rabort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rabort_result",    bus.ALUResult, 32'd0);
        check("rabort_zero",      {31'd0, bus.Zero}, 32'd0);
        check("rabort_busy",      {31'd0, busy}, 32'd0);
        check("rabort_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("rabort_no_result", {31'd0, seen}, 32'd0);

        // ---------------- randomized run vs reference model ----------------
        m_pend = 1'b0; m_held = 1'b0; m_rem = 0; m_pres = '0; m_res = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.Operation = 4'($urandom_range(0, 15));
            bus.SrcA      = $urandom;
            bus.SrcB      = $urandom;
            if ($urandom_range(0, 3) == 0) bus.SrcB[4:0] = 5'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 99) < 3);
            #1;
            m_ready = !m_pend && (!m_held || bus.out_ready) && !flush;
            check("rnd_in_ready",  {31'd0, bus.in_ready}, {31'd0, m_ready});
            check("rnd_out_valid", {31'd0, bus.out_valid}, {31'd0, m_held});
            check("rnd_busy",      {31'd0, busy}, {31'd0, m_pend});
            if (m_held) begin
                check("rnd_result", bus.ALUResult, m_res);
                check("rnd_zero",   {31'd0, bus.Zero}, {31'd0, (m_res == 32'd0)});
            end
            @(posedge clk);
            m_acc = m_ready && bus.in_valid;
            if (flush) begin
                m_pend = 1'b0;
                m_held = 1'b0;
            end else begin
                if (m_held && bus.out_ready) m_held = 1'b0;
                if (m_pend) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_pend = 1'b0;
                        m_held = 1'b1;
                        m_res  = m_pres;
                    end
                end else if (m_acc) begin
                    k = (bus.Operation inside {4'd3, 4'd4, 4'd5}) ? int'(bus.SrcB[4:0]) : 0;
                    if (k == 0) begin
                        m_held = 1'b1;
                        m_res  = ref_alu(bus.Operation, bus.SrcA, bus.SrcB);
                    end else begin
                        m_pend = 1'b1;
                        m_rem  = k;
                        m_pres = ref_alu(bus.Operation, bus.SrcA, bus.SrcB);
                    end
                end
            end
            @(negedge clk);
        end
        flush = 1'b0;
        bus.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
